// File: rtl/dp_scan_n_if.sv
// Display bus for dp_scan_n: scan enable, digit/decimal-point inputs and the
// segment / digit-enable pins. Width follows the digit count.
interface dp_scan_n_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   nums;
    logic [DIGITS-1:0]     dp;
    logic [6:0]            data;
    logic                  dot;
    logic [DIGITS-1:0]     an;

    modport master (
        output en, nums, dp,
        input  data, dot, an
    );

    modport slave (
        input  en, nums, dp,
        output data, dot, an
    );
endinterface

// File: rtl/dp_scan_n.sv
// Time-multiplexed N-digit seven-segment driver with refresh prescaler,
// anti-ghosting blank window, leading-zero suppression and per-frame input snapshot.
module dp_scan_n #(
    parameter int DIGITS     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int DIV        = 1000,
    parameter int BLANK      = 8,
    parameter int LZB        = 1
) (
    input  logic        clk,
    input  logic        rst,
    dp_scan_n_if.slave  bus
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic          POL     = (ACTIVE_LOW != 0);
    localparam logic          LZB_ON  = (LZB != 0);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*DIGITS-1:0]    snum;
    logic [DIGITS-1:0]      sdp;

    logic [6:0]             data_q;
    logic                   dot_q;
    logic [DIGITS-1:0]      an_q;

    logic [DIGITS-1:0]      zero_lead;
    logic                   zero_run;
    logic [3:0]             cur_digit;
    logic                   cur_supp;
    logic                   cur_dp;
    logic [6:0]             data_n;
    logic                   dot_n;
    logic [DIGITS-1:0]      an_n;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Prescaler and digit index; both freeze while the scan is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (bus.en) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Snapshot at frame start only, so one frame never mixes old and new digits.
    // NOTE: the snapshot is a handful of flops, not a memory, so it takes the reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            snum <= '0;
            sdp  <= '0;
        end else if (bus.en && cnt == '0 && idx == '0) begin
            snum <= bus.nums;
            sdp  <= bus.dp;
        end
    end

    // zero_lead[k] is set when snapshot digits k..DIGITS-1 are all zero (k >= 1).
    // NOTE: zero_run is a running value inside one combinational pass, so it uses blocking assignments.
    always_comb begin
        zero_run  = 1'b1;
        zero_lead = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (snum[4*k +: 4] == 4'h0);
            zero_lead[k] = zero_run;
        end
    end

    // Next-cycle pin values in active-high form; polarity is applied at the register.
    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        an_n      = '0;
        data_n    = '0;
        dot_n     = 1'b0;
        cur_digit = snum[4*idx +: 4];
        cur_supp  = LZB_ON && zero_lead[idx];
        cur_dp    = sdp[idx];
        if (bus.en && cnt >= BLANK_C) begin
            dot_n = cur_dp;
            // A suppressed digit still lights its enable when its decimal point is on.
            if (!cur_supp || cur_dp) begin
                an_n[idx] = 1'b1;
            end
            if (!cur_supp) begin
                data_n = hex_to_seg(cur_digit);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {7{POL}};
            dot_q  <= POL;
            an_q   <= {DIGITS{POL}};
        end else begin
            data_q <= data_n ^ {7{POL}};
            dot_q  <= dot_n ^ POL;
            an_q   <= an_n ^ {DIGITS{POL}};
        end
    end

    assign bus.data = data_q;
    assign bus.dot  = dot_q;
    assign bus.an   = an_q;

endmodule

// File: tb/tb_dp_scan_n.sv
// Bench for dp_scan_n: two configurations share stimulus and are checked every
// cycle against a frame-position model, plus literal spot checks.
module tb_dp_scan_n;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int BLANK  = 1;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] nums;
    logic [3:0]  dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: common anode with suppression; b: common cathode without suppression.
    dp_scan_n_if #(.DIGITS(DIGITS)) a_if ();
    dp_scan_n_if #(.DIGITS(DIGITS)) b_if ();

    assign a_if.en = en;  assign a_if.nums = nums;  assign a_if.dp = dp;
    assign b_if.en = en;  assign b_if.nums = nums;  assign b_if.dp = dp;

    dp_scan_n #(.DIGITS(DIGITS), .ACTIVE_LOW(1), .DIV(DIV), .BLANK(BLANK), .LZB(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    dp_scan_n #(.DIGITS(DIGITS), .ACTIVE_LOW(0), .DIV(DIV), .BLANK(BLANK), .LZB(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame counts enabled cycles since reset.
    int          m_pos;
    logic [15:0] m_snum;
    logic [3:0]  m_sdp;
    logic [11:0] exp_a, exp_b;
    bit          exp_valid = 1'b0;

    function automatic logic [11:0] model_out(input bit al, input bit lzb);
        logic [3:0]  an_h = '0;
        logic        dot_h = 1'b0;
        logic [6:0]  d_h = '0;
        logic [15:0] upper;
        logic [11:0] r;
        int          k;
        bit          sup;
        if (en && (m_pos % DIV) >= BLANK) begin
            k     = m_pos / DIV;
            upper = m_snum >> (4 * k);
            sup   = lzb && (k != 0) && (upper == 16'h0);
            dot_h = m_sdp[k];
            if (!sup || m_sdp[k]) an_h = 4'(1 << k);
            if (!sup) d_h = seg_tab[upper[3:0]];
        end
        r = {an_h, dot_h, d_h};
        return al ? ~r : r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_a     <= 12'hFFF;
            exp_b     <= 12'h000;
            m_pos     <= 0;
            m_snum    <= '0;
            m_sdp     <= '0;
            exp_valid <= 1'b1;
        end else begin
            exp_a <= model_out(1'b1, 1'b1);
            exp_b <= model_out(1'b0, 1'b0);
            if (en) begin
                if (m_pos == 0) begin
                    m_snum <= nums;
                    m_sdp  <= dp;
                end
                m_pos <= (m_pos + 1) % FRAME;
            end
        end
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            check("model_a", {a_if.an, a_if.dot, a_if.data}, exp_a);
            check("model_b", {b_if.an, b_if.dot, b_if.data}, exp_b);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a given digit-enable pattern on the common-anode instance.
    task automatic wait_an(input logic [3:0] want, input string name);
        int n = 0;
        while (a_if.an !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting an=%b, got %b", name, want, a_if.an);
        end
    endtask

    logic [6:0] frame_seg [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};

    initial begin
        logic [31:0] r;
        rst  = 1'b1;
        en   = 1'b1;
        nums = 16'h1234;
        dp   = 4'h0;

        repeat (3) begin
            @(negedge clk);
            check("rst_hold_a", {a_if.an, a_if.dot, a_if.data}, {4'hF, 1'b1, 7'h7F});
            check("rst_hold_b", {b_if.an, b_if.dot, b_if.data}, 12'h000);
        end
        rst = 1'b0;

        @(negedge clk);
        check("first_blank_a", {a_if.an, a_if.dot, a_if.data}, {4'hF, 1'b1, 7'h7F});
        repeat (3) begin
            @(negedge clk);
            check("first_lit_a", {a_if.an, a_if.dot, a_if.data}, {4'b1110, 1'b1, 7'h19});
            check("first_lit_b", {b_if.an, b_if.dot, b_if.data}, {4'b0001, 1'b0, 7'h66});
        end
        for (int s = 1; s < 4; s++) begin
            @(negedge clk);
            check("slot_blank_b", {b_if.an, b_if.dot, b_if.data}, 12'h000);
            repeat (3) begin
                @(negedge clk);
                check("slot_lit_b", {b_if.an, b_if.dot, b_if.data}, {4'(1 << s), 1'b0, frame_seg[s]});
                check("slot_lit_a", {a_if.an, a_if.dot, a_if.data}, ~{4'(1 << s), 1'b0, frame_seg[s]});
            end
        end

        // Leading zeros on the suppressing instance.
        nums = 16'h0050;
        cycles(40);
        wait_an(4'b1101, "lz_digit1");
        check("lz_digit1_data", {a_if.dot, a_if.data}, {1'b1, 7'h12});
        wait_an(4'b1110, "lz_digit0");
        check("lz_digit0_data", {a_if.dot, a_if.data}, {1'b1, 7'h40});

        nums = 16'h0000;
        dp   = 4'b0100;
        cycles(40);
        wait_an(4'b1011, "lz_dp_digit2");
        check("lz_dp_digit2_data", {a_if.dot, a_if.data}, {1'b0, 7'h7F});
        dp = 4'h0;

        // Snapshot coherence: change inputs mid-frame.
        nums = 16'h1234;
        cycles(40);
        while (m_pos != 9) @(negedge clk);
        nums = 16'h5678;
        cycles(2 * FRAME);

        // Freeze, then mid-slot reset.
        cycles(6);
        en = 1'b0;
        cycles(5);
        en = 1'b1;
        cycles(2 * FRAME + 3);
        while (m_pos != 14) @(negedge clk);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        nums = 16'h9ABC;
        cycles(2 * FRAME);

        // Randomized traffic; the per-cycle model comparison carries the checking.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) begin
                r    = $urandom;
                nums = r[15:0] >> (4 * $urandom_range(0, 4));
                dp   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
        end
        rst = 1'b0;
        en  = 1'b1;
        cycles(FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
